pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB core. Owns per-stage valid bits and the allowin/ready_go handshake.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_stage_tag.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline sequencer: forward-select encoding,
// the per-stage producer tag, and the tag/forward helper functions.
package pipe_pkg;

  // Tags carry register indices up to this width; narrower GPR indices are zero-extended.
  localparam int TAG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic [TAG_AW-1:0] dest;
    logic              we;
    logic              load;
  } stage_tag_t;

  // A producer only matters if it is valid, really writes, and does not target r0.
  function automatic logic tag_hit(logic valid, stage_tag_t tag,
                                   logic [TAG_AW-1:0] src, logic en);
    return en && valid && tag.we && (tag.dest != '0) && (tag.dest == src);
  endfunction

  function automatic fwd_sel_e pick_fwd(logic hit_ex, logic hit_mem, logic hit_wb);
    if (hit_ex)  return FWD_EX;
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage decode inputs and sequencer outputs of pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              fs_to_ds_valid;
  logic [REG_AW-1:0] id_rj;
  logic [REG_AW-1:0] id_rk;
  logic [REG_AW-1:0] id_rd;
  logic              id_src1_from_ref;
  logic              id_src2_from_ref;
  logic              id_src2_is_rd;
  logic              id_ref_we;
  logic              id_res_from_dram;
  logic              id_br_taken;

  logic              fs_allowin;
  logic              ds_valid;
  logic              es_valid;
  logic              ms_valid;
  logic              ws_valid;
  logic              ds_ready_go;
  logic              br_flush;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output fs_to_ds_valid, id_rj, id_rk, id_rd, id_src1_from_ref, id_src2_from_ref,
           id_src2_is_rd, id_ref_we, id_res_from_dram, id_br_taken,
    input  fs_allowin, ds_valid, es_valid, ms_valid, ws_valid, ds_ready_go,
           br_flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );

  modport slave (
    input  fs_to_ds_valid, id_rj, id_rk, id_rd, id_src1_from_ref, id_src2_from_ref,
           id_src2_is_rd, id_ref_we, id_res_from_dram, id_br_taken,
    output fs_allowin, ds_valid, es_valid, ms_valid, ws_valid, ds_ready_go,
           br_flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_tag.sv
// One pipeline stage slot: valid bit plus producer tag, loaded when the stage allows in.
module pipe_stage_tag
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load_en,
  input  logic       i_valid,
  input  stage_tag_t i_tag,
  output logic       o_valid,
  output stage_tag_t o_tag
);

  logic       r_valid;
  stage_tag_t r_tag;

  // NOTE: the tag is reset along with the valid bit so forward selects read a clean 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_load_en) begin
      // NOTE: non-blocking, so each stage captures its neighbour's pre-edge contents.
      r_valid <= i_valid;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: valid/allowin handshake, RAW forwarding or stall
// on ID sources, wrong-path cancel on taken ID branches, stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              resetn,
  pipe_hazard_ctrl_if.slave bus
);

  logic              r_ds_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_es_valid, w_ms_valid, w_ws_valid;
  stage_tag_t        w_es_tag, w_ms_tag, w_ws_tag, w_id_tag;
  logic [REG_AW-1:0] w_src2_idx;
  logic [TAG_AW-1:0] w_src1, w_src2;
  logic              w_hit1_ex, w_hit1_mem, w_hit1_wb;
  logic              w_hit2_ex, w_hit2_mem, w_hit2_wb;
  logic              w_raw_stall;
  fwd_sel_e          w_fwd1, w_fwd2;
  logic              w_ds_ready_go, w_ds_allowin, w_es_allowin, w_ms_allowin, w_ws_allowin;
  logic              w_br_flush;

  assign w_src2_idx = bus.id_src2_is_rd ? bus.id_rd : bus.id_rk;
  assign w_src1     = TAG_AW'(bus.id_rj);
  assign w_src2     = TAG_AW'(w_src2_idx);
  assign w_id_tag   = '{dest: TAG_AW'(bus.id_rd), we: bus.id_ref_we, load: bus.id_res_from_dram};

  assign w_hit1_ex  = tag_hit(w_es_valid, w_es_tag, w_src1, bus.id_src1_from_ref);
  assign w_hit1_mem = tag_hit(w_ms_valid, w_ms_tag, w_src1, bus.id_src1_from_ref);
  assign w_hit1_wb  = tag_hit(w_ws_valid, w_ws_tag, w_src1, bus.id_src1_from_ref);
  assign w_hit2_ex  = tag_hit(w_es_valid, w_es_tag, w_src2, bus.id_src2_from_ref);
  assign w_hit2_mem = tag_hit(w_ms_valid, w_ms_tag, w_src2, bus.id_src2_from_ref);
  assign w_hit2_wb  = tag_hit(w_ws_valid, w_ws_tag, w_src2, bus.id_src2_from_ref);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    w_raw_stall = 1'b0;
    w_fwd1      = FWD_RF;
    w_fwd2      = FWD_RF;
    if (FWD_EN != 0) begin
      // Only a load still in EX cannot be bypassed; select stays on EX while stalled.
      w_raw_stall = r_ds_valid & w_es_tag.load & (w_hit1_ex | w_hit2_ex);
      w_fwd1      = pick_fwd(w_hit1_ex, w_hit1_mem, w_hit1_wb);
      w_fwd2      = pick_fwd(w_hit2_ex, w_hit2_mem, w_hit2_wb);
    end else begin
      w_raw_stall = r_ds_valid & (w_hit1_ex | w_hit1_mem | w_hit1_wb |
                                  w_hit2_ex | w_hit2_mem | w_hit2_wb);
    end
  end

  // EX, MEM and WB always complete in one cycle, so only ID can hold the pipe.
  assign w_ws_allowin  = 1'b1;
  assign w_ms_allowin  = !w_ms_valid | w_ws_allowin;
  assign w_es_allowin  = !w_es_valid | w_ms_allowin;
  assign w_ds_ready_go = !w_raw_stall;
  assign w_ds_allowin  = !r_ds_valid | (w_ds_ready_go & w_es_allowin);
  assign w_br_flush    = r_ds_valid & bus.id_br_taken & w_ds_ready_go & w_es_allowin;

  pipe_stage_tag u_ex (
    .clk       (clk),
    .rst_n     (resetn),
    .i_load_en (w_es_allowin),
    .i_valid   (r_ds_valid & w_ds_ready_go),
    .i_tag     (w_id_tag),
    .o_valid   (w_es_valid),
    .o_tag     (w_es_tag)
  );

  pipe_stage_tag u_mem (
    .clk       (clk),
    .rst_n     (resetn),
    .i_load_en (w_ms_allowin),
    .i_valid   (w_es_valid),
    .i_tag     (w_es_tag),
    .o_valid   (w_ms_valid),
    .o_tag     (w_ms_tag)
  );

  pipe_stage_tag u_wb (
    .clk       (clk),
    .rst_n     (resetn),
    .i_load_en (w_ws_allowin),
    .i_valid   (w_ms_valid),
    .i_tag     (w_ms_tag),
    .o_valid   (w_ws_valid),
    .o_tag     (w_ws_tag)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ds_valid  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ds_allowin) r_ds_valid <= bus.fs_to_ds_valid & !w_br_flush;
      if (r_ds_valid & !w_ds_ready_go) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.fs_allowin  = w_ds_allowin;
  assign bus.ds_valid    = r_ds_valid;
  assign bus.es_valid    = w_es_valid;
  assign bus.ms_valid    = w_ms_valid;
  assign bus.ws_valid    = w_ws_valid;
  assign bus.ds_ready_go = w_ds_ready_go;
  assign bus.br_flush    = w_br_flush;
  assign bus.fwd_sel1    = w_fwd1;
  assign bus.fwd_sel2    = w_fwd2;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding instance and a stall-only instance
// (4-bit counters) share stimulus; directed table, multi-cycle sequences, random run.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    bit       fsv;
    bit [4:0] rj, rk, rd;
    bit       s1, s2, s2rd, we, ld, br;
  } ins_t;

  typedef struct {
    ins_t     in;
    bit       ds, rg, fl;
    bit [1:0] f1, f2;
    int       sc, fc;
  } vec_t;

  typedef struct packed {
    logic       ds, es, ms, ws, rg, fl, fa;
    logic [1:0] f1, f2;
    logic [31:0] sc, fc;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  ins_t cur = '0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) b0 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  b1 ();

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(32)) dut  (.clk(clk), .resetn(resetn), .bus(b0));
  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(4))  dut0 (.clk(clk), .resetn(resetn), .bus(b1));

  assign b0.fs_to_ds_valid = cur.fsv;  assign b1.fs_to_ds_valid = cur.fsv;
  assign b0.id_rj = cur.rj;            assign b1.id_rj = cur.rj;
  assign b0.id_rk = cur.rk;            assign b1.id_rk = cur.rk;
  assign b0.id_rd = cur.rd;            assign b1.id_rd = cur.rd;
  assign b0.id_src1_from_ref = cur.s1; assign b1.id_src1_from_ref = cur.s1;
  assign b0.id_src2_from_ref = cur.s2; assign b1.id_src2_from_ref = cur.s2;
  assign b0.id_src2_is_rd = cur.s2rd;  assign b1.id_src2_is_rd = cur.s2rd;
  assign b0.id_ref_we = cur.we;        assign b1.id_ref_we = cur.we;
  assign b0.id_res_from_dram = cur.ld; assign b1.id_res_from_dram = cur.ld;
  assign b0.id_br_taken = cur.br;      assign b1.id_br_taken = cur.br;

  obs_t obs [2];
  assign obs[0] = '{ds: b0.ds_valid, es: b0.es_valid, ms: b0.ms_valid, ws: b0.ws_valid,
                    rg: b0.ds_ready_go, fl: b0.br_flush, fa: b0.fs_allowin,
                    f1: b0.fwd_sel1, f2: b0.fwd_sel2, sc: b0.stall_cnt, fc: b0.flush_cnt};
  assign obs[1] = '{ds: b1.ds_valid, es: b1.es_valid, ms: b1.ms_valid, ws: b1.ws_valid,
                    rg: b1.ds_ready_go, fl: b1.br_flush, fa: b1.fs_allowin,
                    f1: b1.fwd_sel1, f2: b1.fwd_sel2, sc: 32'(b1.stall_cnt), fc: 32'(b1.flush_cnt)};

  // Reference model: ID valid plus a list of the three older in-flight instructions
  // (index 1 = one instruction ahead of ID, 3 = three ahead). Instance 0 forwards.
  bit          m_ds [2];
  bit          m_v  [2][4];
  bit [4:0]    m_dest [2][4];
  bit          m_we [2][4];
  bit          m_ld [2][4];
  int unsigned m_sc [2];
  int unsigned m_fc [2];
  bit          e_rg [2];
  bit          e_fl [2];
  bit          e_fa [2];
  int          e_f1 [2];
  int          e_f2 [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Distance to the youngest older instruction that writes src, 0 if none.
  function automatic int first_hit(int d, bit en, bit [4:0] src);
    if (!en || src == 0) return 0;
    for (int k = 1; k <= 3; k++)
      if (m_v[d][k] && m_we[d][k] && m_dest[d][k] == src) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ds[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      for (int k = 0; k < 4; k++) begin
        m_v[d][k] = 0; m_dest[d][k] = 0; m_we[d][k] = 0; m_ld[d][k] = 0;
      end
    end
  endtask

  task automatic model_eval();
    int k1, k2;
    bit stall;
    for (int d = 0; d < 2; d++) begin
      k1 = first_hit(d, cur.s1, cur.rj);
      k2 = first_hit(d, cur.s2, cur.s2rd ? cur.rd : cur.rk);
      if (d == 0) begin
        stall   = m_ds[d] && m_ld[d][1] && (k1 == 1 || k2 == 1);
        e_f1[d] = k1;
        e_f2[d] = k2;
      end else begin
        stall   = m_ds[d] && (k1 != 0 || k2 != 0);
        e_f1[d] = 0;
        e_f2[d] = 0;
      end
      e_rg[d] = !stall;
      e_fl[d] = m_ds[d] && cur.br && !stall;
      e_fa[d] = !m_ds[d] || !stall;
    end
  endtask

  task automatic model_tick();
    model_eval();
    for (int d = 0; d < 2; d++) begin
      if (m_ds[d] && !e_rg[d]) m_sc[d]++;
      if (e_fl[d]) m_fc[d]++;
      for (int k = 3; k >= 2; k--) begin
        m_v[d][k] = m_v[d][k-1]; m_dest[d][k] = m_dest[d][k-1];
        m_we[d][k] = m_we[d][k-1]; m_ld[d][k] = m_ld[d][k-1];
      end
      m_v[d][1] = m_ds[d] && e_rg[d];
      m_dest[d][1] = cur.rd; m_we[d][1] = cur.we; m_ld[d][1] = cur.ld;
      if (!m_ds[d] || e_rg[d]) m_ds[d] = cur.fsv && !e_fl[d];
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] mask;
    model_eval();
    for (int d = 0; d < 2; d++) begin
      mask = (d == 0) ? 32'hffff_ffff : 32'h0000_000f;
      check($sformatf("%s d%0d ds_valid", tag, d), 32'(obs[d].ds), 32'(m_ds[d]));
      check($sformatf("%s d%0d es_valid", tag, d), 32'(obs[d].es), 32'(m_v[d][1]));
      check($sformatf("%s d%0d ms_valid", tag, d), 32'(obs[d].ms), 32'(m_v[d][2]));
      check($sformatf("%s d%0d ws_valid", tag, d), 32'(obs[d].ws), 32'(m_v[d][3]));
      check($sformatf("%s d%0d ds_ready_go", tag, d), 32'(obs[d].rg), 32'(e_rg[d]));
      check($sformatf("%s d%0d br_flush", tag, d), 32'(obs[d].fl), 32'(e_fl[d]));
      check($sformatf("%s d%0d fs_allowin", tag, d), 32'(obs[d].fa), 32'(e_fa[d]));
      check($sformatf("%s d%0d fwd_sel1", tag, d), 32'(obs[d].f1), 32'(e_f1[d]));
      check($sformatf("%s d%0d fwd_sel2", tag, d), 32'(obs[d].f2), 32'(e_f2[d]));
      check($sformatf("%s d%0d stall_cnt", tag, d), obs[d].sc, m_sc[d] & mask);
      check($sformatf("%s d%0d flush_cnt", tag, d), obs[d].fc, m_fc[d] & mask);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input ins_t in);
    @(negedge clk);
    cur = in;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cur = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_model("reset");
    resetn = 1'b1;
  endtask

  function automatic ins_t mk(bit fsv, int rj, int rk, int rd,
                              bit s1, bit s2, bit s2rd, bit we, bit ld, bit br);
    mk = '{fsv: fsv, rj: 5'(rj), rk: 5'(rk), rd: 5'(rd),
           s1: s1, s2: s2, s2rd: s2rd, we: we, ld: ld, br: br};
  endfunction

  function automatic vec_t mkv(ins_t in, bit ds, bit rg, int f1, int f2, bit fl, int sc, int fc);
    mkv.in = in; mkv.ds = ds; mkv.rg = rg; mkv.f1 = 2'(f1); mkv.f2 = 2'(f2);
    mkv.fl = fl; mkv.sc = sc; mkv.fc = fc;
  endfunction

  vec_t tbl [17];

  initial begin
    ins_t nop1, nop0, add_r3, sub_r5, ri;
    nop1   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop0   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_r3 = mk(1, 1, 2, 3, 1, 1, 0, 1, 0, 0);
    sub_r5 = mk(1, 3, 1, 5, 1, 1, 0, 1, 0, 0);

    //             in (fsv rj rk rd s1 s2 s2rd we ld br)     ds rg f1 f2 fl sc fc
    tbl[0]  = mkv(nop1,                                      0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(add_r3,                                    1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(mk(1, 3, 5, 4, 1, 1, 0, 1, 0, 0),          1, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mkv(mk(1, 2, 0, 6, 1, 0, 0, 1, 1, 0),          1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(mk(1, 6, 0, 7, 1, 0, 0, 1, 0, 0),          1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mkv(mk(1, 6, 0, 7, 1, 0, 0, 1, 0, 0),          1, 1, 2, 0, 0, 1, 0);
    tbl[6]  = mkv(mk(1, 1, 0, 1, 1, 1, 1, 0, 0, 1),          1, 1, 0, 0, 1, 1, 0);
    tbl[7]  = mkv(nop1,                                      0, 1, 0, 0, 0, 1, 1);
    tbl[8]  = mkv(mk(1, 2, 0, 8, 1, 0, 0, 1, 1, 0),          1, 1, 0, 0, 0, 1, 1);
    tbl[9]  = mkv(mk(1, 8, 0, 0, 1, 1, 1, 0, 0, 1),          1, 0, 1, 0, 0, 1, 1);
    tbl[10] = mkv(mk(1, 8, 0, 0, 1, 1, 1, 0, 0, 1),          1, 1, 2, 0, 1, 2, 1);
    tbl[11] = mkv(nop1,                                      0, 1, 0, 0, 0, 2, 2);
    tbl[12] = mkv(mk(1, 1, 2, 0, 1, 1, 0, 1, 0, 0),          1, 1, 0, 0, 0, 2, 2);
    tbl[13] = mkv(mk(1, 0, 0, 4, 1, 1, 0, 1, 0, 0),          1, 1, 0, 0, 0, 2, 2);
    tbl[14] = mkv(mk(1, 1, 2, 9, 1, 1, 0, 1, 0, 0),          1, 1, 0, 0, 0, 2, 2);
    tbl[15] = mkv(mk(0, 1, 0, 9, 1, 1, 1, 0, 0, 0),          1, 1, 0, 1, 0, 2, 2);
    tbl[16] = mkv(nop0,                                      0, 1, 0, 0, 0, 2, 2);

    do_reset();

    // Directed program on the forwarding instance.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d ds_valid", i),    32'(obs[0].ds), 32'(tbl[i].ds));
      check($sformatf("vec%0d ds_ready_go", i), 32'(obs[0].rg), 32'(tbl[i].rg));
      check($sformatf("vec%0d fwd_sel1", i),    32'(obs[0].f1), 32'(tbl[i].f1));
      check($sformatf("vec%0d fwd_sel2", i),    32'(obs[0].f2), 32'(tbl[i].f2));
      check($sformatf("vec%0d br_flush", i),    32'(obs[0].fl), 32'(tbl[i].fl));
      check($sformatf("vec%0d stall_cnt", i),   obs[0].sc,      32'(tbl[i].sc));
      check($sformatf("vec%0d flush_cnt", i),   obs[0].fc,      32'(tbl[i].fc));
      if (i == 5) check("load-use bubble es_valid", 32'(obs[0].es), 32'd0);
      check_model($sformatf("vec%0d", i));
      tick();
    end

    // Stall-only instance: a dependent sub waits for add r3 to leave WB.
    do_reset();
    step(nop1);   check_model("nofwd a"); tick();
    step(add_r3); check_model("nofwd b"); tick();
    for (int i = 0; i < 4; i++) begin
      step(sub_r5);
      check($sformatf("nofwd ready_go %0d", i), 32'(obs[1].rg), (i < 3) ? 32'd0 : 32'd1);
      check($sformatf("nofwd stall_cnt %0d", i), obs[1].sc, 32'(i));
      check($sformatf("fwd no stall %0d", i), 32'(obs[0].rg), 32'd1);
      check_model($sformatf("nofwd c%0d", i));
      tick();
    end

    // Reset asserted in the middle of a stall clears everything at once.
    do_reset();
    step(nop1);   check_model("rstmid a"); tick();
    step(add_r3); check_model("rstmid b"); tick();
    step(sub_r5); check_model("rstmid c"); tick();
    step(sub_r5);
    check("rstmid pre stall_cnt", obs[1].sc, 32'd1);
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rstmid d%0d valids", d),
            32'({obs[d].ds, obs[d].es, obs[d].ms, obs[d].ws}), 32'd0);
      check($sformatf("rstmid d%0d stall_cnt", d), obs[d].sc, 32'd0);
      check($sformatf("rstmid d%0d flush_cnt", d), obs[d].fc, 32'd0);
      check($sformatf("rstmid d%0d fwd_sel", d), 32'({obs[d].f1, obs[d].f2}), 32'd0);
    end
    model_reset();
    #1;
    resetn = 1'b1;
    tick();

    // Random traffic over a small register window; ID holds its instruction while stalled.
    ri = nop1;
    for (int n = 0; n < 800; n++) begin
      if (n == 0 || e_rg[0]) begin
        ri.fsv  = ($urandom_range(0, 5) != 0);
        ri.rj   = 5'($urandom_range(0, 7));
        ri.rk   = 5'($urandom_range(0, 7));
        ri.rd   = 5'($urandom_range(0, 7));
        ri.s1   = ($urandom_range(0, 4) != 0);
        ri.s2   = ($urandom_range(0, 2) != 0);
        ri.s2rd = ($urandom_range(0, 3) == 0);
        ri.we   = ($urandom_range(0, 4) != 0);
        ri.ld   = ($urandom_range(0, 3) == 0);
        ri.br   = ($urandom_range(0, 7) == 0);
      end
      step(ri);
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
